// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter.
// Bus command encodings, requester ids, tag-owner entry.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_cmd_e;

  typedef enum logic {
    DCACHE = 1'b0,
    ICACHE = 1'b1
  } req_e;

  typedef struct packed {
    logic valid;
    req_e owner;
  } owner_ent_t;

endpackage

// File: rtl/mem_tag_table.sv
// Tag-owner table: records who owns each memory tag.
// Ports: alloc (en/tag/owner), return lookup (tag -> hit/owner), sticky err_o.
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  req_e             alloc_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic             ret_hit,
  output req_e             ret_owner,
  output logic             err_o
);

  localparam int N = 1 << TAG_W;

  owner_ent_t tbl [N];
  logic       err;
  logic       bad_ret;
  logic       reuse;

  always_comb begin
    ret_hit   = (ret_tag != '0) && tbl[ret_tag].valid;
    ret_owner = ret_hit ? tbl[ret_tag].owner : DCACHE;
    bad_ret   = (ret_tag != '0) && !tbl[ret_tag].valid;
    // A tag freed in this same cycle may be reused cleanly.
    reuse     = alloc_en && tbl[alloc_tag].valid &&
                !(ret_hit && (ret_tag == alloc_tag));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        tbl[k].valid <= 1'b0;
      end
      err <= 1'b0;
    end else begin
      if (ret_hit) begin
        tbl[ret_tag].valid <= 1'b0;
      end
      // Alloc after free so a same-cycle reallocation wins.
      if (alloc_en) begin
        tbl[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
      end
      if (bad_ret || reuse) begin
        err <= 1'b1;
      end
    end
  end

  assign err_o = err;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of Dcache and Icache onto the memory port.
// Ports: d_*/i_* requests+acks, proc2mem_* command, mem2proc_* returns, rsp_*, err_o.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int MEM_TAG_W = 4,
  parameter int D_MAX_OUT = 8,
  parameter int I_MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_req_i,
  input  logic [1:0]           d_cmd_i,
  input  logic [ADDR_W-1:0]    d_addr_i,
  input  logic [63:0]          d_data_i,
  input  logic                 i_req_i,
  input  logic [ADDR_W-1:0]    i_addr_i,
  input  logic [MEM_TAG_W-1:0] mem2proc_response_i,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag_i,
  input  logic [63:0]          mem2proc_data_i,
  output logic [1:0]           proc2mem_command_o,
  output logic [ADDR_W-1:0]    proc2mem_addr_o,
  output logic [63:0]          proc2mem_data_o,
  output logic                 d_ack_o,
  output logic [MEM_TAG_W-1:0] d_ack_tag_o,
  output logic                 i_ack_o,
  output logic [MEM_TAG_W-1:0] i_ack_tag_o,
  output logic                 d_rsp_vld_o,
  output logic                 i_rsp_vld_o,
  output logic [MEM_TAG_W-1:0] rsp_tag_o,
  output logic [63:0]          rsp_data_o,
  output logic                 err_o
);

  localparam int DCW = $clog2(D_MAX_OUT + 1);
  localparam int ICW = $clog2(I_MAX_OUT + 1);

  logic [DCW-1:0] d_cnt;
  logic [ICW-1:0] i_cnt;
  req_e           last_gnt;

  logic d_load;
  logic elig_d;
  logic elig_i;
  logic gnt_d;
  logic gnt_i;
  logic accept;
  logic alloc_en;
  req_e alloc_owner;
  logic ret_hit;
  req_e ret_owner;
  logic d_inc;
  logic d_dec;
  logic i_inc;
  logic i_dec;

  always_comb begin
    d_load = (d_cmd_i != BUS_STORE);
    elig_d = d_req_i &&
             (!d_load || (d_cnt < DCW'(D_MAX_OUT)));
    elig_i = i_req_i && (i_cnt < ICW'(I_MAX_OUT));
    // On a tie, the side that did not win last goes.
    gnt_d  = elig_d &&
             (!elig_i || (last_gnt == ICACHE));
    gnt_i  = elig_i && !gnt_d;
    accept = (gnt_d || gnt_i) &&
             (mem2proc_response_i != '0);
    alloc_en    = accept && (gnt_i || d_load);
    alloc_owner = gnt_i ? ICACHE : DCACHE;
    d_inc = accept && gnt_d && d_load;
    i_inc = accept && gnt_i;
    d_dec = ret_hit && (ret_owner == DCACHE);
    i_dec = ret_hit && (ret_owner == ICACHE);
  end

  always_comb begin
    proc2mem_command_o = BUS_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    unique case (1'b1)
      gnt_d: begin
        proc2mem_command_o = d_cmd_i;
        proc2mem_addr_o    = d_addr_i;
        proc2mem_data_o    = d_data_i;
      end
      gnt_i: begin
        proc2mem_command_o = BUS_LOAD;
        proc2mem_addr_o    = i_addr_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    d_ack_o     = accept && gnt_d;
    i_ack_o     = accept && gnt_i;
    d_ack_tag_o = d_ack_o ? mem2proc_response_i : '0;
    i_ack_tag_o = i_ack_o ? mem2proc_response_i : '0;
    d_rsp_vld_o = d_dec;
    i_rsp_vld_o = i_dec;
    rsp_tag_o   = mem2proc_tag_i;
    rsp_data_o  = (mem2proc_tag_i != '0) ?
                  mem2proc_data_i : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_cnt    <= '0;
      i_cnt    <= '0;
      last_gnt <= ICACHE;
    end else begin
      if (accept) begin
        last_gnt <= alloc_owner;
      end
      if (d_inc && !d_dec && (d_cnt < DCW'(D_MAX_OUT))) begin
        d_cnt <= d_cnt + 1'b1;
      end else if (d_dec && !d_inc && (d_cnt != '0)) begin
        d_cnt <= d_cnt - 1'b1;
      end
      if (i_inc && !i_dec && (i_cnt < ICW'(I_MAX_OUT))) begin
        i_cnt <= i_cnt + 1'b1;
      end else if (i_dec && !i_inc && (i_cnt != '0)) begin
        i_cnt <= i_cnt - 1'b1;
      end
    end
  end

  mem_tag_table #(
    .TAG_W (MEM_TAG_W)
  ) u_tbl (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response_i),
    .alloc_owner (alloc_owner),
    .ret_tag     (mem2proc_tag_i),
    .ret_hit     (ret_hit),
    .ret_owner   (ret_owner),
    .err_o       (err_o)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Directed scenarios plus randomized traffic against a reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        d_req;
  logic [1:0]  d_cmd;
  logic [63:0] d_addr;
  logic [63:0] d_data;
  logic        i_req;
  logic [63:0] i_addr;
  logic [3:0]  resp;
  logic [3:0]  rtag;
  logic [63:0] rdata;

  logic [1:0]  cmd_o;
  logic [63:0] addr_o;
  logic [63:0] data_o;
  logic        d_ack;
  logic [3:0]  d_ack_tag;
  logic        i_ack;
  logic [3:0]  i_ack_tag;
  logic        d_rsp;
  logic        i_rsp;
  logic [3:0]  rsp_tag;
  logic [63:0] rsp_data;
  logic        err;

  int checks;
  int failures;

  mem_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .d_req_i             (d_req),
    .d_cmd_i             (d_cmd),
    .d_addr_i            (d_addr),
    .d_data_i            (d_data),
    .i_req_i             (i_req),
    .i_addr_i            (i_addr),
    .mem2proc_response_i (resp),
    .mem2proc_tag_i      (rtag),
    .mem2proc_data_i     (rdata),
    .proc2mem_command_o  (cmd_o),
    .proc2mem_addr_o     (addr_o),
    .proc2mem_data_o     (data_o),
    .d_ack_o             (d_ack),
    .d_ack_tag_o         (d_ack_tag),
    .i_ack_o             (i_ack),
    .i_ack_tag_o         (i_ack_tag),
    .d_rsp_vld_o         (d_rsp),
    .i_rsp_vld_o         (i_rsp),
    .rsp_tag_o           (rsp_tag),
    .rsp_data_o          (rsp_data),
    .err_o               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner table (0 = Dcache, 1 = Icache), counts, rr pointer.
  bit m_vld [16];
  bit m_own [16];
  int m_dcnt;
  int m_icnt;
  bit m_last;
  bit m_err;

  bit          e_gd, e_gi, e_acc, e_hit;
  logic [1:0]  e_cmd;
  logic [63:0] e_addr, e_data;

  task automatic model_eval();
    bit ed, ei;
    ed = d_req && (d_cmd == BUS_STORE || m_dcnt < 8);
    ei = i_req && m_icnt < 4;
    e_gd = 0;
    e_gi = 0;
    if (ed && ei) begin
      if (m_last) e_gd = 1;
      else e_gi = 1;
    end else begin
      e_gd = ed;
      e_gi = ei;
    end
    e_acc  = (e_gd || e_gi) && resp != 0;
    e_hit  = rtag != 0 && m_vld[rtag];
    e_cmd  = e_gd ? d_cmd : (e_gi ? BUS_LOAD : BUS_NONE);
    e_addr = e_gd ? d_addr : (e_gi ? i_addr : 64'd0);
    e_data = e_gd ? d_data : 64'd0;
  endtask

  task automatic model_update();
    if (rst) begin
      for (int k = 0; k < 16; k++) m_vld[k] = 0;
      m_dcnt = 0;
      m_icnt = 0;
      m_last = 1;
      m_err  = 0;
    end else begin
      model_eval();
      if (e_hit) begin
        m_vld[rtag] = 0;
        if (m_own[rtag]) m_icnt = m_icnt - 1;
        else m_dcnt = m_dcnt - 1;
      end else if (rtag != 0) begin
        m_err = 1;
      end
      if (e_acc) begin
        m_last = e_gi;
        if (e_gi || d_cmd != BUS_STORE) begin
          if (m_vld[resp]) m_err = 1;
          m_vld[resp] = 1;
          m_own[resp] = e_gi;
          if (e_gi) m_icnt = m_icnt + 1;
          else m_dcnt = m_dcnt + 1;
        end
      end
      if (m_dcnt < 0) m_dcnt = 0;
      if (m_dcnt > 8) m_dcnt = 8;
      if (m_icnt < 0) m_icnt = 0;
      if (m_icnt > 4) m_icnt = 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input bit dr, input logic [1:0] dc,
                        input logic [63:0] da, input logic [63:0] dd,
                        input bit ir, input logic [63:0] ia,
                        input logic [3:0] rs, input logic [3:0] tg,
                        input logic [63:0] rd);
    d_req = dr; d_cmd = dc; d_addr = da; d_data = dd;
    i_req = ir; i_addr = ia;
    resp = rs; rtag = tg; rdata = rd;
  endtask

  task automatic idle();
    set_in(0, BUS_NONE, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    #1;
    checks++;
    if (cmd_o !== 2'b00 || addr_o !== 0 || data_o !== 0) begin
      failures++;
      $display("FAIL reset_cmd got=%0h/%0h/%0h want=0", cmd_o, addr_o, data_o);
    end
    checks++;
    if ({d_ack, i_ack, d_rsp, i_rsp, err} !== 5'b0 ||
        d_ack_tag !== 0 || i_ack_tag !== 0 || rsp_data !== 0) begin
      failures++;
      $display("FAIL reset_outs got=%b want=0", {d_ack, i_ack, d_rsp, i_rsp, err});
    end
    checks++;
    if (dut.d_cnt !== 0 || dut.i_cnt !== 0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0", dut.d_cnt, dut.i_cnt);
    end
  endtask

  task automatic test_basic();
    do_reset();
    set_in(1, BUS_LOAD, 64'hA0, 0, 1, 64'hB0, 3, 0, 0);
    #1;
    checks++;
    if (d_ack !== 1 || d_ack_tag !== 3 || i_ack !== 0 || addr_o !== 64'hA0) begin
      failures++;
      $display("FAIL basic_d_ack got=%b tag=%0d i=%b want=1 tag=3 i=0", d_ack, d_ack_tag, i_ack);
    end
    tick();
    resp = 5;
    #1;
    checks++;
    if (i_ack !== 1 || i_ack_tag !== 5 || d_ack !== 0 || addr_o !== 64'hB0) begin
      failures++;
      $display("FAIL basic_i_ack got=%b tag=%0d want=1 tag=5", i_ack, i_ack_tag);
    end
    tick();
    set_in(0, BUS_NONE, 0, 0, 0, 0, 0, 5, 64'hDEAD);
    #1;
    checks++;
    if (i_rsp !== 1 || d_rsp !== 0 || rsp_tag !== 5 || rsp_data !== 64'hDEAD) begin
      failures++;
      $display("FAIL basic_i_rsp got=%b/%b tag=%0d want=1/0 tag=5", i_rsp, d_rsp, rsp_tag);
    end
    tick();
    idle();
    #1;
    checks++;
    if (dut.i_cnt !== 0 || dut.d_cnt !== 1 || err !== 0) begin
      failures++;
      $display("FAIL basic_cnt got=%0d/%0d err=%b want=1/0 err=0", dut.d_cnt, dut.i_cnt, err);
    end
  endtask

  task automatic test_store();
    do_reset();
    set_in(1, BUS_STORE, 64'hC0, 64'h1234, 0, 0, 7, 0, 0);
    #1;
    checks++;
    if (d_ack !== 1 || cmd_o !== BUS_STORE || data_o !== 64'h1234) begin
      failures++;
      $display("FAIL store_ack got=%b cmd=%0d data=%0h want=1 cmd=2 data=1234", d_ack, cmd_o, data_o);
    end
    tick();
    set_in(0, BUS_NONE, 0, 0, 0, 0, 0, 7, 64'h55);
    #1;
    checks++;
    if (dut.d_cnt !== 0 || d_rsp !== 0 || i_rsp !== 0) begin
      failures++;
      $display("FAIL store_noentry got=cnt%0d rsp%b%b want=0 00", dut.d_cnt, d_rsp, i_rsp);
    end
    tick();
    idle();
    #1;
    checks++;
    if (err !== 1) begin
      failures++;
      $display("FAIL store_err got=%b want=1", err);
    end
  endtask

  task automatic test_credits();
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      set_in(0, BUS_NONE, 0, 0, 1, 64'h100, 4'(t), 0, 0);
      tick();
    end
    set_in(0, BUS_NONE, 0, 0, 1, 64'h100, 5, 0, 0);
    #1;
    checks++;
    if (i_ack !== 0 || cmd_o !== BUS_NONE) begin
      failures++;
      $display("FAIL credit_block got=%b cmd=%0d want=0 cmd=0", i_ack, cmd_o);
    end
    tick();
    set_in(1, BUS_LOAD, 64'h200, 0, 1, 64'h100, 8, 0, 0);
    #1;
    checks++;
    if (d_ack !== 1 || d_ack_tag !== 8 || i_ack !== 0) begin
      failures++;
      $display("FAIL credit_d_wins got=%b/%b want=1/0", d_ack, i_ack);
    end
    tick();
    set_in(0, BUS_NONE, 0, 0, 1, 64'h100, 0, 2, 0);
    #1;
    checks++;
    if (i_rsp !== 1 || d_rsp !== 0) begin
      failures++;
      $display("FAIL credit_ret got=%b want=1", i_rsp);
    end
    tick();
    resp = 9;
    rtag = 0;
    #1;
    checks++;
    if (i_ack !== 1 || i_ack_tag !== 9) begin
      failures++;
      $display("FAIL credit_reenable got=%b tag=%0d want=1 tag=9", i_ack, i_ack_tag);
    end
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    set_in(1, BUS_LOAD, 64'h300, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (d_ack !== 0 || cmd_o !== BUS_LOAD || addr_o !== 64'h300) begin
        failures++;
        $display("FAIL hold_c%0d got=ack%b cmd%0d want=ack0 cmd1", c, d_ack, cmd_o);
      end
      tick();
    end
    resp = 9;
    #1;
    checks++;
    if (d_ack !== 1 || d_ack_tag !== 9) begin
      failures++;
      $display("FAIL hold_accept got=%b tag=%0d want=1 tag=9", d_ack, d_ack_tag);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_in(1, BUS_LOAD, 64'h400, 0, 0, 0, 6, 0, 0);
    tick();
    set_in(1, BUS_LOAD, 64'h440, 0, 0, 0, 6, 6, 64'h77);
    #1;
    checks++;
    if (d_rsp !== 1 || d_ack !== 1 || d_ack_tag !== 6) begin
      failures++;
      $display("FAIL same_both got=rsp%b ack%b want=rsp1 ack1", d_rsp, d_ack);
    end
    tick();
    set_in(0, BUS_NONE, 0, 0, 0, 0, 0, 6, 64'h88);
    #1;
    checks++;
    if (dut.d_cnt !== 1 || err !== 0 || d_rsp !== 1) begin
      failures++;
      $display("FAIL same_state got=cnt%0d err%b rsp%b want=cnt1 err0 rsp1", dut.d_cnt, err, d_rsp);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(1, BUS_LOAD, 64'h500, 0, 0, 0, 1, 0, 0);
    tick();
    resp = 2;
    tick();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if (dut.d_cnt !== 0 || err !== 0) begin
      failures++;
      $display("FAIL rstmid_state got=cnt%0d err%b want=cnt0 err0", dut.d_cnt, err);
    end
    rtag = 1;
    #1;
    checks++;
    if (d_rsp !== 0 || i_rsp !== 0) begin
      failures++;
      $display("FAIL rstmid_drop got=%b%b want=00", d_rsp, i_rsp);
    end
    tick();
    idle();
    #1;
    checks++;
    if (err !== 1) begin
      failures++;
      $display("FAIL rstmid_err got=%b want=1", err);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_in($urandom_range(0, 1),
             ($urandom_range(0, 3) == 0) ? BUS_STORE : BUS_LOAD,
             {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 1), {$urandom, $urandom},
             ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
             ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
             {$urandom, $urandom});
      #1;
      model_eval();
      checks++;
      if (cmd_o !== e_cmd || addr_o !== e_addr || data_o !== e_data) begin
        failures++;
        $display("FAIL rnd_cmd n=%0d got=%0d %0h %0h want=%0d %0h %0h",
                 n, cmd_o, addr_o, data_o, e_cmd, e_addr, e_data);
      end
      checks++;
      if (d_ack !== (e_acc && e_gd) || i_ack !== (e_acc && e_gi) ||
          d_ack_tag !== ((e_acc && e_gd) ? resp : 4'd0) ||
          i_ack_tag !== ((e_acc && e_gi) ? resp : 4'd0)) begin
        failures++;
        $display("FAIL rnd_ack n=%0d got=%b%b want=%b%b", n, d_ack, i_ack,
                 e_acc && e_gd, e_acc && e_gi);
      end
      checks++;
      if (d_rsp !== (e_hit && !m_own[rtag]) || i_rsp !== (e_hit && m_own[rtag]) ||
          rsp_tag !== rtag || rsp_data !== ((rtag != 0) ? rdata : 64'd0)) begin
        failures++;
        $display("FAIL rnd_rsp n=%0d got=%b%b want=%b%b", n, d_rsp, i_rsp,
                 e_hit && !m_own[rtag], e_hit && m_own[rtag]);
      end
      checks++;
      if (err !== m_err) begin
        failures++;
        $display("FAIL rnd_err n=%0d got=%b want=%b", n, err, m_err);
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    idle();
    test_reset();
    test_basic();
    test_store();
    test_credits();
    test_hold();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
